// File: rtl/aer_arbiter.sv
// aer_arbiter: merges N_SRC asynchronous AER channels onto one 4-phase output bus.
// Requests and the core acknowledge are synchronized; grants follow a round-robin pointer.
module aer_arbiter #(
   parameter int N_SRC     = 4,
   parameter int ADDR_BITS = 9,
   parameter int SRC_BITS  = $clog2(N_SRC)
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [N_SRC-1:0]                    SRC_REQ,
   input  logic [N_SRC-1:0][ADDR_BITS-1:0]     SRC_ADDR,
   output logic [N_SRC-1:0]                    SRC_ACK,
   output logic [SRC_BITS+ADDR_BITS-1:0]       AEROUT_ADDR,
   output logic                                AEROUT_REQ,
   input  logic                                AEROUT_ACK,
   output logic                                BUSY,
   output logic [15:0]                         EVENT_CNT
);

   localparam int OUT_BITS = SRC_BITS + ADDR_BITS;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SETUP    = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK = 2'd2;
   localparam logic [1:0] ST_WAIT_REL = 2'd3;

   logic [N_SRC-1:0]    req_meta_r;
   logic [N_SRC-1:0]    req_sync_r;
   logic                ack_meta_r;
   logic                ack_sync_r;
   logic [1:0]          state_r;
   logic [1:0]          state_nxt_s;
   logic [SRC_BITS-1:0] ptr_r;
   logic [SRC_BITS-1:0] ptr_nxt_s;
   logic [SRC_BITS-1:0] grant_r;
   logic [SRC_BITS-1:0] grant_nxt_s;
   logic [SRC_BITS-1:0] sel_s;
   logic                found_s;
   logic                aerout_req_r;
   logic                aerout_req_nxt_s;
   logic [N_SRC-1:0]    src_ack_r;
   logic [N_SRC-1:0]    src_ack_nxt_s;
   logic [OUT_BITS-1:0] aerout_addr_r;
   logic [OUT_BITS-1:0] aerout_addr_nxt_s;
   logic                busy_r;
   logic [15:0]         event_cnt_r;
   logic [15:0]         event_cnt_nxt_s;

   // Two-flop synchronizers for the asynchronous handshake inputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         req_meta_r <= '0;
         req_sync_r <= '0;
         ack_meta_r <= 1'b0;
         ack_sync_r <= 1'b0;
      end else begin
         req_meta_r <= SRC_REQ;
         req_sync_r <= req_meta_r;
         ack_meta_r <= AEROUT_ACK;
         ack_sync_r <= ack_meta_r;
      end
   end

   // Round-robin search: first synchronized request at or above ptr_r, wrapping.
   always_comb begin
      found_s = 1'b0;
      sel_s   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         sel_s   = (!found_s && req_sync_r[SRC_BITS'((int'(ptr_r) + k) % N_SRC)])
                   ? SRC_BITS'((int'(ptr_r) + k) % N_SRC) : sel_s;
         found_s = found_s | req_sync_r[SRC_BITS'((int'(ptr_r) + k) % N_SRC)];
      end
   end

   // Handshake sequencer: grant, address setup, core ack, source release.
   always_comb begin
      state_nxt_s       = state_r;
      ptr_nxt_s         = ptr_r;
      grant_nxt_s       = grant_r;
      aerout_req_nxt_s  = aerout_req_r;
      src_ack_nxt_s     = src_ack_r;
      aerout_addr_nxt_s = aerout_addr_r;
      event_cnt_nxt_s   = event_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               grant_nxt_s       = sel_s;
               aerout_addr_nxt_s = {sel_s, SRC_ADDR[sel_s]};
               state_nxt_s       = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            aerout_req_nxt_s = 1'b1;
            state_nxt_s      = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ack_sync_r) begin
               aerout_req_nxt_s = 1'b0;
               src_ack_nxt_s    = N_SRC'(1'b1) << grant_r;
               state_nxt_s      = ST_WAIT_REL;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         ST_WAIT_REL: begin
            if (!ack_sync_r && !req_sync_r[grant_r]) begin
               src_ack_nxt_s   = '0;
               event_cnt_nxt_s = event_cnt_r + 16'd1;
               state_nxt_s     = ST_IDLE;
               if (grant_r == SRC_BITS'(N_SRC - 1)) begin
                  ptr_nxt_s = '0;
               end else begin
                  ptr_nxt_s = grant_r + SRC_BITS'(1);
               end
            end else begin
               state_nxt_s = ST_WAIT_REL;
            end
         end
         default: begin
            aerout_req_nxt_s = 1'b0;
            src_ack_nxt_s    = '0;
            state_nxt_s      = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops the handshake lines immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r       <= ST_IDLE;
         ptr_r         <= '0;
         grant_r       <= '0;
         aerout_req_r  <= 1'b0;
         src_ack_r     <= '0;
         aerout_addr_r <= '0;
         busy_r        <= 1'b0;
         event_cnt_r   <= 16'd0;
      end else begin
         state_r       <= state_nxt_s;
         ptr_r         <= ptr_nxt_s;
         grant_r       <= grant_nxt_s;
         aerout_req_r  <= aerout_req_nxt_s;
         src_ack_r     <= src_ack_nxt_s;
         aerout_addr_r <= aerout_addr_nxt_s;
         busy_r        <= (state_nxt_s != ST_IDLE);
         event_cnt_r   <= event_cnt_nxt_s;
      end
   end

   assign SRC_ACK     = src_ack_r;
   assign AEROUT_ADDR = aerout_addr_r;
   assign AEROUT_REQ  = aerout_req_r;
   assign BUSY        = busy_r;
   assign EVENT_CNT   = event_cnt_r;

endmodule

// File: tb/tb_aer_arbiter.sv
// Scoreboard bench for aer_arbiter: source and core handshake models drive the DUT,
// a monitor pops expected merged addresses on every grant and checks the protocol.
module tb_aer_arbiter;

   localparam int N  = 4;
   localparam int AB = 9;
   localparam int SB = 2;

   logic                  clk;
   logic                  rst;
   logic [N-1:0]          src_req;
   logic [N-1:0][AB-1:0]  src_addr;
   logic [N-1:0]          src_ack;
   logic [SB+AB-1:0]      aer_addr;
   logic                  aer_req;
   logic                  aer_ack;
   logic                  busy;
   logic [15:0]           event_cnt;

   int                    total;
   int                    bad;
   logic [SB+AB-1:0]      sb_q[$];
   int                    src_total[N];
   int                    issued[N];
   int                    core_delay;
   int                    core_cnt;

   aer_arbiter #(.N_SRC(N), .ADDR_BITS(AB)) dut (
      .CLK         (clk),
      .RST         (rst),
      .SRC_REQ     (src_req),
      .SRC_ADDR    (src_addr),
      .SRC_ACK     (src_ack),
      .AEROUT_ADDR (aer_addr),
      .AEROUT_REQ  (aer_req),
      .AEROUT_ACK  (aer_ack),
      .BUSY        (busy),
      .EVENT_CNT   (event_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_done(input string name, input logic [15:0] cnt, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (event_cnt == cnt && !busy && sb_q.size() == 0) break;
      end
      check({name, "_cnt"}, 32'(event_cnt), 32'(cnt));
      check({name, "_idle"}, 32'(busy), 32'd0);
      check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
   endtask

   // Core model: acks about 100 ns after the merged request, releases after it drops.
   initial begin
      aer_ack  = 1'b0;
      core_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) begin
            aer_ack  = 1'b0;
            core_cnt = 0;
         end else if (aer_req && !aer_ack) begin
            if (core_cnt >= core_delay) begin
               aer_ack  = 1'b1;
               core_cnt = 0;
            end else begin
               core_cnt++;
            end
         end else if (!aer_req) begin
            aer_ack  = 1'b0;
            core_cnt = 0;
         end
      end
   end

   // Source models: raise a request while more are owed, drop it once acked.
   initial begin
      src_req = '0;
      for (int i = 0; i < N; i++) issued[i] = 0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (src_ack[i]) begin
               src_req[i] = 1'b0;
            end else if (!src_req[i] && issued[i] < src_total[i]) begin
               src_req[i] = 1'b1;
               issued[i]++;
            end
         end
      end
   end

   // Monitor: scoreboard pop on each grant plus handshake protocol checks.
   initial begin
      logic             prev_busy;
      logic             prev_req;
      logic             exp_req_next;
      logic             ack_h1;
      logic             ack_h2;
      logic [SB+AB-1:0] prev_addr;
      logic [SB+AB-1:0] e;
      prev_busy = 1'b0; prev_req = 1'b0; exp_req_next = 1'b0;
      ack_h1 = 1'b0; ack_h2 = 1'b0; prev_addr = '0; e = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_busy = 1'b0; prev_req = 1'b0; exp_req_next = 1'b0;
            ack_h1 = 1'b0; ack_h2 = 1'b0; prev_addr = '0;
         end else begin
            check("ack_onehot", 32'($countones(src_ack) <= 1), 32'd1);
            if (exp_req_next) begin
               check("req_one_cycle_after_grant", 32'(aer_req), 32'd1);
               exp_req_next = 1'b0;
            end
            if (busy && !prev_busy) begin
               check("grant_queued", 32'(sb_q.size() > 0), 32'd1);
               check("req_low_at_grant", 32'(aer_req), 32'd0);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("grant_addr", 32'(aer_addr), 32'(e));
               end
               exp_req_next = 1'b1;
            end
            if (prev_req && !aer_req)
               check("src_ack_on_req_fall", 32'(src_ack), 32'd1 << e[SB+AB-1:AB]);
            if (prev_req && aer_req)
               check("addr_stable", 32'(aer_addr), 32'(prev_addr));
            if (!prev_req && aer_req)
               check("req_rise_ack_clear", 32'({ack_h2, ack_h1}), 32'd0);
            prev_busy = busy;
            prev_req  = aer_req;
            prev_addr = aer_addr;
            ack_h2    = ack_h1;
            ack_h1    = aer_ack;
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      src_addr   = '0;
      core_delay = 9;
      for (int i = 0; i < N; i++) src_total[i] = 0;
      repeat (3) @(negedge clk);
      check("rst_req", 32'(aer_req), 32'd0);
      check("rst_ack", 32'(src_ack), 32'd0);
      check("rst_addr", 32'(aer_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(event_cnt), 32'd0);
      #2 rst = 1'b1;

      // single source 2, address 0x0A5 -> {2, 0x0A5}
      src_addr[2] = 9'h0A5;
      sb_q.push_back(11'h4A5);
      src_total[2] += 1;
      wait_done("single", 16'd1, 400);

      // all four sources requesting from reset -> order 0,1,2,3
      @(negedge clk);
      #2 rst = 1'b0;
      src_addr[0] = 9'h001; src_addr[1] = 9'h002;
      src_addr[2] = 9'h003; src_addr[3] = 9'h004;
      sb_q.push_back(11'h001); sb_q.push_back(11'h202);
      sb_q.push_back(11'h403); sb_q.push_back(11'h604);
      for (int i = 0; i < N; i++) src_total[i] += 1;
      repeat (3) @(negedge clk);
      check("simul_rst_cnt", 32'(event_cnt), 32'd0);
      #2 rst = 1'b1;
      wait_done("simul", 16'd4, 800);

      // sources 0 and 3 both re-requesting -> 0,3,0,3
      src_addr[0] = 9'h011;
      src_addr[3] = 9'h133;
      sb_q.push_back(11'h011); sb_q.push_back(11'h733);
      sb_q.push_back(11'h011); sb_q.push_back(11'h733);
      src_total[0] += 2;
      src_total[3] += 2;
      wait_done("rr", 16'd8, 1200);

      // reset while waiting for the core ack, then regrant of the held request
      core_delay  = 40;
      src_addr[1] = 9'h055;
      sb_q.push_back(11'h255);
      src_total[1] += 1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (aer_req) break;
      end
      check("abort_req_up", 32'(aer_req), 32'd1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_req", 32'(aer_req), 32'd0);
      check("abort_ack", 32'(src_ack), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cnt", 32'(event_cnt), 32'd0);
      check("abort_addr", 32'(aer_addr), 32'd0);
      core_delay = 9;
      sb_q.push_back(11'h255);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      wait_done("abort_regrant", 16'd1, 400);

      // counter wrap from 0xFFFF with the maximum source address
      force dut.event_cnt_r = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.event_cnt_r;
      @(negedge clk);
      check("preload", 32'(event_cnt), 32'h0000FFFF);
      src_addr[0] = 9'h1FF;
      sb_q.push_back(11'h1FF);
      src_total[0] += 1;
      wait_done("wrap", 16'd0, 400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
